multi_alarm_clock: RTL
======================

# multi_alarm_clock

Single-clock-domain 24-hour real-time clock with `NUM_ALARMS` independently settable alarms, per-alarm enables, snooze and auto-timeout. It is the parametrised successor to the single-alarm clock. All state advances on one system clock gated by an internal one-second tick enable; no derived clocks are generated. It sits between the board switch/key debouncers and the seven-segment/LED drivers.

## Interface
- `NUM_ALARMS`, 4: number of alarm channels (1..8).
- `TICK_DIV`, 50_000_000: clk cycles per second.
- `SNOOZE_MIN`, 5: snooze length in minutes (1..59).
- `RING_SEC`, 60: seconds an alarm rings before auto-dismiss (1..255).
- `clk  in  1`: system clock.
- `reset  in  1`: asynchronous, active-high.
- `run  in  1`: 1 = timekeeping advances. 0 = time frozen and prescaler held.
- `set_time  in  1`: time-set mode.
- `set_alarm  in  1`: alarm-set mode. Ignored while `set_time`=1.
- `sel_hr  in  1`: field for `inc`. 1 = hours, 0 = minutes.
- `alarm_sel  in  $clog2(NUM_ALARMS) (min 1)`: alarm addressed by set and readback.
- `inc  in  1`: single-cycle pulse that increments the selected field.
- `alarm_en  in  NUM_ALARMS`: per-alarm arm.
- `snooze  in  1`: single-cycle pulse.
- `dismiss  in  1`: single-cycle pulse.
- `sec, min  out  6`: current time, binary.
- `hrs  out  5`: current hours, binary 0..23.
- `al_min  out  6`: minutes of alarm `alarm_sel`.
- `al_hrs  out  5`: hours of alarm `alarm_sel`.
- `ringing  out  NUM_ALARMS`: per-alarm ring state.
- `alarm  out  1`: OR of `ringing`.
- `sec_tick  out  1`: one-cycle pulse on each time advance.

## Operation
- Prescaler counts 0..TICK_DIV-1 while `run`=1 and `set_time`=0. On terminal count it wraps to 0 and fires `sec_tick`. It is cleared while `set_time`=1.
- On `sec_tick`, `sec` increments. At 59 it wraps to 0 and carries into `min`. `min` at 59 wraps to 0 and carries into `hrs`. `hrs` at 23 wraps to 0.
- Time set (`set_time`=1): `inc` adds 1 to `min` (59→0, no carry) or `hrs` (23→0). Every `inc` also clears `sec` to 0.
- Alarm set (`set_alarm`=1, `set_time`=0): `inc` adds 1 to the `alarm_sel` entry with the same wrap rules. The entry's ring state is unaffected.
- Out-of-range `alarm_sel`: `inc` ignored; readback returns 0.
- Each alarm has an FSM with states IDLE, RINGING and SNOOZED:
  - IDLE→RINGING when `sec_tick` loads hh:mm:00 equal to the alarm time and `alarm_en[i]`=1.
  - RINGING→SNOOZED on `snooze`. The snooze target is the current time plus SNOOZE_MIN minutes, wrapping at 24 h.
  - SNOOZED→RINGING when `sec_tick` loads target:00.
  - RINGING→IDLE on `dismiss`, or after RING_SEC `sec_tick`s in RINGING (per-alarm 8-bit counter).
  - Any state→IDLE on `dismiss`, or when `alarm_en[i]`=0.
- `snooze` and `dismiss` act on every alarm simultaneously.
- Priority order: `alarm_en`=0, then `dismiss`, then `snooze`, then match.
- Several alarms may ring at once.

## Timing
- Reset values:
  - `sec`, `min`, `hrs`, the prescaler and every alarm time are 0.
  - All FSMs are IDLE, with `ringing`=0, `alarm`=0 and `sec_tick`=0.
- Reset mid-ring clears everything immediately (asynchronous).
- The time registers update on the clk edge after the cycle where the prescaler hits terminal count. `sec_tick` is high that same cycle, so it is registered in step with the time update.
- `ringing[i]` rises on the same edge that loads the matching time, so latency from `sec_tick` is 0.
- `snooze` and `dismiss` take effect on the next edge: `ringing` falls 1 cycle after the pulse.
- `inc` updates the target register on the next edge. The readback outputs are combinational from `alarm_sel`.
- Match is evaluated only on `sec_tick` edges. If the clock is set past an alarm, the alarm does not fire.

## Configuration
- `MULTI_ALARM_SNOOZE_EN` defined: SNOOZED state, per-alarm snooze target registers and the `snooze` input are active.
- Undefined: the `snooze` port still exists but is ignored. The FSM is IDLE/RINGING only, and no snooze registers are synthesised.

## Test plan
Parameters for all scenarios: TICK_DIV=4, NUM_ALARMS=4, SNOOZE_MIN=5, RING_SEC=10.
- Rollover: set 23:59 via `inc` with `set_time`, release, run 60 ticks → 00:00:00 with `hrs` wrap, and `sec_tick` every 4 cycles.
- Multi-alarm: alarm0=alarm2=00:01, both enabled, start at 00:00:00 → `ringing`=4'b0101 on the edge loading 00:01:00, `alarm`=1.
- Snooze: alarm0 ringing at 00:01, `snooze` pulse → `ringing[0]`=0 next cycle, then re-rings at 00:06:00. With the macro undefined it stays ringing.
- Timeout/dismiss: ringing alarm left alone → IDLE after 10 ticks. A second ring with `dismiss` plus `snooze` in the same cycle → IDLE (dismiss wins).
- Enable drop and reset: `alarm_en[1]`→0 while ringing clears `ringing[1]` next cycle. Asserting `reset` mid-ring clears all outputs immediately, and alarm readback returns 00:00.

Source files
------------

// File: rtl/multi_alarm_clock.sv
// 24-hour RTC with NUM_ALARMS independent alarms, ring timeout and optional snooze.
// Define MULTI_ALARM_SNOOZE_EN to build the SNOOZED state and per-alarm snooze targets.
module multi_alarm_clock #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  localparam int unsigned SelW      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  set_time,
  input  logic                  set_alarm,
  input  logic                  sel_hr,
  input  logic [SelW-1:0]       alarm_sel,
  input  logic                  inc,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [5:0]            sec,
  output logic [5:0]            min,
  output logic [4:0]            hrs,
  output logic [5:0]            al_min,
  output logic [4:0]            al_hrs,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm,
  output logic                  sec_tick
);

  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SelWp = SelW + 1;
  localparam logic [PreW-1:0]  PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [SelW:0]    NumSel  = SelWp'(NUM_ALARMS);
  localparam logic [7:0]       RingMax = 8'(RING_SEC - 1);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} al_state_e;

  logic [PreW-1:0] pre_q, pre_d;
  logic [5:0]      sec_q, sec_d, min_q, min_d;
  logic [4:0]      hrs_q, hrs_d;
  logic            tick, sec_tick_q, sel_ok, minute_edge;

  logic [5:0] al_min_q [NUM_ALARMS];
  logic [5:0] al_min_d [NUM_ALARMS];
  logic [4:0] al_hrs_q [NUM_ALARMS];
  logic [4:0] al_hrs_d [NUM_ALARMS];
  logic [7:0] ring_cnt_q [NUM_ALARMS];
  logic [7:0] ring_cnt_d [NUM_ALARMS];
  al_state_e  st_q [NUM_ALARMS];
  al_state_e  st_d [NUM_ALARMS];

`ifdef MULTI_ALARM_SNOOZE_EN
  logic [5:0] tgt_min_q [NUM_ALARMS];
  logic [5:0] tgt_min_d [NUM_ALARMS];
  logic [4:0] tgt_hrs_q [NUM_ALARMS];
  logic [4:0] tgt_hrs_d [NUM_ALARMS];
  logic [6:0] snz_sum;
  logic [5:0] snz_min;
  logic [4:0] snz_hrs;

  always_comb begin
    snz_sum = {1'b0, min_q} + 7'(SNOOZE_MIN);
    snz_min = 6'(snz_sum);
    snz_hrs = hrs_q;
    if (snz_sum >= 7'd60) begin
      snz_min = 6'(snz_sum - 7'd60);
      snz_hrs = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Timekeeping: set mode freezes the prescaler; otherwise a tick advances the time.
  always_comb begin
    pre_d = pre_q;
    sec_d = sec_q;
    min_d = min_q;
    hrs_d = hrs_q;
    tick  = 1'b0;
    if (set_time) begin
      pre_d = '0;
      if (inc) begin
        sec_d = '0;
        if (sel_hr) hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
        else        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
    end else if (run) begin
      if (pre_q == PreMax) begin
        pre_d = '0;
        tick  = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  assign sel_ok      = ({1'b0, alarm_sel} < NumSel);
  assign minute_edge = tick && (sec_d == 6'd0);

  // Matches compare against the time being loaded, so ringing rises on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      al_min_d[i]   = al_min_q[i];
      al_hrs_d[i]   = al_hrs_q[i];
      ring_cnt_d[i] = ring_cnt_q[i];
      st_d[i]       = st_q[i];
`ifdef MULTI_ALARM_SNOOZE_EN
      tgt_min_d[i]  = tgt_min_q[i];
      tgt_hrs_d[i]  = tgt_hrs_q[i];
`endif
      if (set_alarm && !set_time && inc && sel_ok && (alarm_sel == SelW'(i))) begin
        if (sel_hr) al_hrs_d[i] = (al_hrs_q[i] == 5'd23) ? 5'd0 : al_hrs_q[i] + 5'd1;
        else        al_min_d[i] = (al_min_q[i] == 6'd59) ? 6'd0 : al_min_q[i] + 6'd1;
      end
      if (!alarm_en[i] || dismiss) begin
        st_d[i] = StIdle;
      end else begin
        unique case (st_q[i])
          StIdle: begin
            if (minute_edge && (min_d == al_min_q[i]) && (hrs_d == al_hrs_q[i])) begin
              st_d[i]       = StRing;
              ring_cnt_d[i] = '0;
            end
          end
          StRing: begin
`ifdef MULTI_ALARM_SNOOZE_EN
            if (snooze) begin
              st_d[i]      = StSnooze;
              tgt_min_d[i] = snz_min;
              tgt_hrs_d[i] = snz_hrs;
            end else
`endif
            if (tick) begin
              if (ring_cnt_q[i] == RingMax) st_d[i] = StIdle;
              else                          ring_cnt_d[i] = ring_cnt_q[i] + 8'd1;
            end
          end
`ifdef MULTI_ALARM_SNOOZE_EN
          StSnooze: begin
            if (minute_edge && (min_d == tgt_min_q[i]) && (hrs_d == tgt_hrs_q[i])) begin
              st_d[i]       = StRing;
              ring_cnt_d[i] = '0;
            end
          end
`endif
          default: st_d[i] = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hrs_q      <= '0;
      sec_tick_q <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_min_q[i]   <= '0;
        al_hrs_q[i]   <= '0;
        ring_cnt_q[i] <= '0;
        st_q[i]       <= StIdle;
`ifdef MULTI_ALARM_SNOOZE_EN
        tgt_min_q[i]  <= '0;
        tgt_hrs_q[i]  <= '0;
`endif
      end
    end else begin
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hrs_q      <= hrs_d;
      sec_tick_q <= tick;
      al_min_q   <= al_min_d;
      al_hrs_q   <= al_hrs_d;
      ring_cnt_q <= ring_cnt_d;
      st_q       <= st_d;
`ifdef MULTI_ALARM_SNOOZE_EN
      tgt_min_q  <= tgt_min_d;
      tgt_hrs_q  <= tgt_hrs_d;
`endif
    end
  end

  always_comb begin
    ringing = '0;
    for (int i = 0; i < NUM_ALARMS; i++) ringing[i] = (st_q[i] == StRing);
  end

  assign alarm    = |ringing;
  assign sec_tick = sec_tick_q;
  assign sec      = sec_q;
  assign min      = min_q;
  assign hrs      = hrs_q;
  assign al_min   = sel_ok ? al_min_q[alarm_sel] : 6'd0;
  assign al_hrs   = sel_ok ? al_hrs_q[alarm_sel] : 5'd0;

endmodule
